// File: rtl/program_loader.sv
// Boot loader: framed byte stream -> word writes at LOAD_BASE.
// Holds the core in reset until the image checksum verifies.
module program_loader #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256,
  parameter int LOAD_BASE = 212
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          mem_addr,
  output logic                 mem_write_en,
  output logic [MEM_WIDTH-1:0] mem_write_val,
  output logic                 core_reset,
  output logic                 load_done,
  output logic                 load_error
);

  localparam logic [15:0] MAX_WORDS = 16'(MEM_SIZE - LOAD_BASE);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] widx;
  logic [1:0]  bcnt;
  logic [23:0] acc;
  logic [7:0]  sum;

  logic        take;
  logic [15:0] len_full;
  logic [15:0] widx_next;

  assign in_ready = !reset &&
    (state inside {LEN_HI, LEN_LO, DATA, CSUM});
  assign take      = in_valid && in_ready;
  assign len_full  = {len[15:8], in_data};
  assign widx_next = widx + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LEN_HI;
      len           <= '0;
      widx          <= '0;
      bcnt          <= '0;
      acc           <= '0;
      sum           <= '0;
      mem_addr      <= '0;
      mem_write_en  <= 1'b0;
      mem_write_val <= '0;
      core_reset    <= 1'b1;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
    end else begin
      mem_write_en <= 1'b0;
      if (take) begin
        unique case (state)
          LEN_HI: begin
            len[15:8] <= in_data;
            sum       <= sum + in_data;
            state     <= LEN_LO;
          end
          LEN_LO: begin
            len[7:0] <= in_data;
            sum      <= sum + in_data;
            if (len_full > MAX_WORDS) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            sum  <= sum + in_data;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              mem_write_val <= {acc, in_data};
              mem_addr      <= 32'(LOAD_BASE) + {16'd0, widx};
              mem_write_en  <= 1'b1;
              widx          <= widx_next;
              if (widx_next == len)
                state <= CSUM;
            end else begin
              acc <= {acc[15:0], in_data};
            end
          end
          CSUM: begin
            if (in_data == sum) begin
              state      <= DONE;
              load_done  <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting upstream of the single-cycle core and its shared word-addressed memory. It accepts a framed byte stream (length header, big-endian 32-bit instruction/data words, checksum), writes each assembled word into memory starting at the core's reset PC, and holds the core in reset until the image has loaded and its checksum has verified. On a framing or checksum failure it latches an error and never releases the core.

## Interface
Parameters:
- MEM_WIDTH, 32, memory word width in bits; the byte-assembly logic supports 32 only.
- MEM_SIZE, 256, number of memory words; word addresses are 0..MEM_SIZE-1.
- LOAD_BASE, 212, word address of the first loaded word; equals the core's PC_START.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_addr  out  32  memory word address for the write.
- mem_write_en  out  1  one-cycle write strobe.
- mem_write_val  out  32  word to write.
- core_reset  out  1  reset to the core; high until the load succeeds.
- load_done  out  1  image loaded and checksum matched (sticky).
- load_error  out  1  length out of range or checksum mismatch (sticky).

## Operation
- States: LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR. Reset enters LEN_HI.
- A byte is accepted when in_valid and in_ready are both high at a rising edge. in_ready is high in LEN_HI, LEN_LO, DATA, and CSUM. It is low in DONE and ERROR, and low in the cycle reset is sampled.
- LEN_HI: the accepted byte becomes N[15:8]; go to LEN_LO.
- LEN_LO: the accepted byte becomes N[7:0]. Then:
  - if N > MEM_SIZE - LOAD_BASE (44 at defaults), go to ERROR;
  - else if N == 0, go to CSUM;
  - else go to DATA.
- DATA: bytes arrive big-endian, first byte is bits [31:24]. A 2-bit byte counter and a 16-bit word index run. When the 4th byte of a word is accepted:
  - register mem_write_val = the assembled word;
  - register mem_addr = LOAD_BASE + word index, zero-extended to 32 bits;
  - set mem_write_en for the next cycle only;
  - increment the word index.
  - After the 4th byte of word N-1, go to CSUM.
- Checksum: an 8-bit running sum, mod 256, of every accepted byte from LEN_HI through the last DATA byte. The CSUM byte is not included. In CSUM, the accepted byte is compared with the sum: equal goes to DONE, unequal goes to ERROR.
- DONE and ERROR are terminal; only reset leaves them. Bytes offered in these states are not accepted and have no effect.
- Words written before an ERROR remain in memory. The core is never released, so they are harmless.

## Timing
- Reset values:
  - in_ready=0 during the reset cycle, 1 from the first cycle after it;
  - mem_addr=0, mem_write_val=0, mem_write_en=0;
  - core_reset=1, load_done=0, load_error=0;
  - byte counter, word index, N and checksum all cleared.
- All outputs are registered except in_ready, which decodes the registered state.
- Throughput is one byte per cycle. Gaps in in_valid stall the loader without changing any state.
- Write latency: mem_write_en is high exactly in the cycle after the edge that accepted a word's 4th byte. mem_addr and mem_write_val are stable in that cycle and hold their values afterwards.
- The CSUM byte can be accepted at the earliest in the same cycle as the final write strobe. The transition to DONE therefore follows the last write, and memory is complete before the core leaves reset.
- core_reset falls, and load_done rises, in the cycle after the matching CSUM byte is accepted. load_error rises in the cycle after the failing byte is accepted.
- Reset in any state, including mid-word, aborts the load the following cycle. Partial bytes and counters are discarded, core_reset is forced to 1, and the next load starts at LEN_HI and writes from LOAD_BASE again.
- Address arithmetic is 32-bit. It cannot exceed MEM_SIZE-1 because N is bounded in LEN_LO.

## Test plan
- Nominal load: bytes 00 02 20 08 00 05 AC 08 00 00 E3.
  - Writes 0x20080005 to 212, then 0xAC080000 to 213, one strobe each.
  - load_done=1 and core_reset=0 one cycle after the E3 byte.
- Empty image: bytes 00 00 00 -> DONE with no mem_write_en pulse, core_reset=0.
- Checksum mismatch: nominal stream with last byte E4.
  - Both writes still occur, then load_error=1 and core_reset stays 1.
  - in_ready=0, and further bytes are ignored.
- Length bounds:
  - 00 2D -> load_error=1 after the 2nd byte, no writes;
  - 00 2C followed by 176 data bytes and the correct checksum -> 44 writes to 212..255 and load_done=1.
- Stall and abort:
  - nominal stream with in_valid low on alternate cycles gives the same writes and result;
  - reset asserted after the 6th byte, then the full nominal stream, gives writes at 212 and 213 and load_done=1.
- Post-done inertness: in DONE, drive in_valid=1 with byte 0xFF for 10 cycles -> no strobes, outputs unchanged.
